// File: rtl/npc_seq_ctrl_if.sv
// Fetch and load/store handshake bundle between the NPC sequencer and its memory ports.
interface npc_seq_ctrl_if;
    logic ifu_req_valid;
    logic ifu_req_ready;
    logic ifu_resp_valid;
    logic lsu_req_valid;
    logic lsu_req_ready;
    logic lsu_req_wen;
    logic lsu_resp_valid;

    modport master (
        output ifu_req_valid,
        input  ifu_req_ready,
        input  ifu_resp_valid,
        output lsu_req_valid,
        input  lsu_req_ready,
        output lsu_req_wen,
        input  lsu_resp_valid
    );

    modport slave (
        input  ifu_req_valid,
        output ifu_req_ready,
        output ifu_resp_valid,
        input  lsu_req_valid,
        output lsu_req_ready,
        input  lsu_req_wen,
        output lsu_resp_valid
    );
endinterface

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle fetch/execute/memory/writeback sequencer for the NPC core, with
// halt/fault detection, a per-handshake watchdog and a retired-instruction counter.
module npc_seq_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    npc_seq_ctrl_if.master   bus,
    output logic             inst_wen,
    input  logic             dec_dram_en,
    input  logic             dec_dram_wen,
    input  logic             dec_rf_wen,
    input  logic             dec_ebreak,
    input  logic             dec_illegal,
    output logic             rf_wen,
    output logic             pc_wen,
    output logic             halt,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [2:0]       state
);
    localparam int              WC_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IF_REQ   = 3'd0,
        S_IF_WAIT  = 3'd1,
        S_EX       = 3'd2,
        S_MEM_REQ  = 3'd3,
        S_MEM_WAIT = 3'd4,
        S_WB       = 3'd5,
        S_HALT     = 3'd6,
        S_ERR      = 3'd7
    } state_t;

    state_t          cur;
    logic [WC_W-1:0] wait_cnt;
    logic            hs;
    logic            wait_st;
    logic            expire;

    // hs is the handshake that lets the current wait state exit
    always_comb begin
        hs      = 1'b0;
        wait_st = 1'b1;
        case (cur)
            S_IF_REQ:   hs = bus.ifu_req_ready;
            S_IF_WAIT:  hs = bus.ifu_resp_valid;
            S_MEM_REQ:  hs = bus.lsu_req_ready;
            S_MEM_WAIT: hs = bus.lsu_resp_valid;
            default:    wait_st = 1'b0;
        endcase
    end

    assign expire = (TIMEOUT != 0) && wait_st && !hs && (wait_cnt == WC_LAST);
    assign state  = cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur        <= S_IF_REQ;
            wait_cnt   <= '0;
            err_code   <= 2'd0;
            retire_cnt <= '0;
        end else if (expire) begin
            cur      <= S_ERR;
            wait_cnt <= '0;
            err_code <= (cur == S_IF_REQ || cur == S_IF_WAIT) ? 2'd2 : 2'd3;
        end else begin
            case (cur)
                S_IF_REQ:   if (bus.ifu_req_ready)  cur <= S_IF_WAIT;
                S_IF_WAIT:  if (bus.ifu_resp_valid) cur <= S_EX;
                S_EX: begin
                    if (dec_ebreak) begin
                        cur <= S_HALT;
                    end else if (dec_illegal) begin
                        cur      <= S_ERR;
                        err_code <= 2'd1;
                    end else if (dec_dram_en) begin
                        cur <= S_MEM_REQ;
                    end else begin
                        cur <= S_WB;
                    end
                end
                S_MEM_REQ:  if (bus.lsu_req_ready)  cur <= S_MEM_WAIT;
                S_MEM_WAIT: if (bus.lsu_resp_valid) cur <= S_WB;
                S_WB: begin
                    retire_cnt <= retire_cnt + CNT_W'(1);
                    cur        <= S_IF_REQ;
                end
                default: ;
            endcase
            // Non-wait states always leave (or are absorbing), so the count only runs while stalled
            if (hs || !wait_st) wait_cnt <= '0;
            else                wait_cnt <= wait_cnt + WC_W'(1);
        end
    end

    always_comb begin
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_wen   = 1'b0;
        inst_wen          = 1'b0;
        rf_wen            = 1'b0;
        pc_wen            = 1'b0;
        halt              = 1'b0;
        err               = 1'b0;
        if (!rst) begin
            case (cur)
                S_IF_REQ:  bus.ifu_req_valid = 1'b1;
                S_IF_WAIT: inst_wen = bus.ifu_resp_valid;
                S_MEM_REQ: begin
                    bus.lsu_req_valid = 1'b1;
                    bus.lsu_req_wen   = dec_dram_wen;
                end
                S_WB: begin
                    rf_wen = dec_rf_wen;
                    pc_wen = 1'b1;
                end
                S_HALT:    halt = 1'b1;
                S_ERR:     err = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Bench for npc_seq_ctrl: per-instruction expected cycle traces built from the
// sequencing rules, driven with directed and randomized handshake delays.
module tb_npc_seq_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dec_dram_en, dec_dram_wen, dec_rf_wen, dec_ebreak, dec_illegal;
    logic          inst_wen, rf_wen, pc_wen, halt, err;
    logic [1:0]    err_code;
    logic [CW-1:0] retire_cnt;
    logic [2:0]    state;
    int            checks = 0;
    int            failures = 0;
    int            ncyc = 0;

    npc_seq_ctrl_if bus();

    npc_seq_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .inst_wen(inst_wen),
        .dec_dram_en(dec_dram_en), .dec_dram_wen(dec_dram_wen), .dec_rf_wen(dec_rf_wen),
        .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
        .rf_wen(rf_wen), .pc_wen(pc_wen), .halt(halt), .err(err),
        .err_code(err_code), .retire_cnt(retire_cnt), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    // One expected clock cycle: stimulus plus the phase the instruction should be in
    typedef struct {
        logic ifr, ifs, lr, ls;
        logic de, dw, drf, deb, dil;
        int   ph;
        logic [1:0] ec;
        int   rc;
    } cyc_t;

    cyc_t       plan[$];
    logic       i_de, i_dw, i_drf, i_deb, i_dil;
    int         rc_m = 0;
    int         term_ph = 0;
    logic [1:0] ec_m = 2'd0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s@%0d got=%0h exp=%0h", nm, ncyc, got, exp);
        end
    endtask

    function automatic void add(input int ph, input logic ifr, ifs, lr, ls);
        cyc_t c;
        c.ifr = ifr; c.ifs = ifs; c.lr = lr; c.ls = ls;
        c.de = i_de; c.dw = i_dw; c.drf = i_drf; c.deb = i_deb; c.dil = i_dil;
        c.ph = ph; c.ec = ec_m; c.rc = rc_m;
        plan.push_back(c);
    endfunction

    // A wait phase lasts del+1 cycles, or TO cycles and then faults when del >= TO
    task automatic push_wait(input int ph, input int del, input int which, output bit to);
        int n;
        logic [3:0] v;
        n = (del >= TO) ? TO : del + 1;
        for (int i = 0; i < n; i++) begin
            v = 4'($urandom);
            v[which] = (del < TO) && (i == del);
            add(ph, v[0], v[1], v[2], v[3]);
        end
        to = (del >= TO);
        if (to) begin
            ec_m    = (ph <= 1) ? 2'd2 : 2'd3;
            term_ph = 7;
        end
    endtask

    task automatic push_instr(input logic de, dw, drf, deb, dil,
                              input int rd, sd, mrd, msd, output bit term);
        bit to;
        i_de = de; i_dw = dw; i_drf = drf; i_deb = deb; i_dil = dil;
        term = 1'b1;
        push_wait(0, rd, 0, to);
        if (to) return;
        push_wait(1, sd, 1, to);
        if (to) return;
        add(2, rb(), rb(), rb(), rb());
        if (deb) begin
            term_ph = 6;
            return;
        end
        if (dil) begin
            ec_m    = 2'd1;
            term_ph = 7;
            return;
        end
        if (de) begin
            push_wait(3, mrd, 2, to);
            if (to) return;
            push_wait(4, msd, 3, to);
            if (to) return;
        end
        add(5, rb(), rb(), rb(), rb());
        rc_m = (rc_m + 1) % (1 << CW);
        term = 1'b0;
    endtask

    task automatic push_absorb(input int n);
        for (int i = 0; i < n; i++) begin
            i_de = rb(); i_dw = rb(); i_drf = rb(); i_deb = rb(); i_dil = rb();
            add(term_ph, rb(), rb(), rb(), rb());
        end
    endtask

    task automatic push_rand(output bit term);
        int k;
        int d[4];
        k = $urandom_range(0, 19);
        for (int i = 0; i < 4; i++)
            d[i] = ($urandom_range(0, 24) == 0) ? TO : $urandom_range(0, TO - 1);
        push_instr((k >= 3) && rb(), rb(), rb(), k < 2, (k == 2) || ((k < 2) && rb()),
                   d[0], d[1], d[2], d[3], term);
    endtask

    task automatic drive_zero();
        bus.ifu_req_ready = 1'b0; bus.ifu_resp_valid = 1'b0;
        bus.lsu_req_ready = 1'b0; bus.lsu_resp_valid = 1'b0;
        dec_dram_en = 1'b0; dec_dram_wen = 1'b0; dec_rf_wen = 1'b0;
        dec_ebreak = 1'b0; dec_illegal = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive_zero();
        rc_m = 0; ec_m = 2'd0; term_ph = 0;
        plan.delete();
        @(negedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ifu_valid", 32'(bus.ifu_req_valid), 32'd0);
        chk("rst_lsu_valid", 32'(bus.lsu_req_valid), 32'd0);
        chk("rst_pc_wen", 32'(pc_wen), 32'd0);
        chk("rst_retire", 32'(retire_cnt), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
    endtask

    task automatic run_plan();
        cyc_t c;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            @(negedge clk);
            rst = 1'b0;
            bus.ifu_req_ready = c.ifr; bus.ifu_resp_valid = c.ifs;
            bus.lsu_req_ready = c.lr;  bus.lsu_resp_valid = c.ls;
            dec_dram_en = c.de; dec_dram_wen = c.dw; dec_rf_wen = c.drf;
            dec_ebreak = c.deb; dec_illegal = c.dil;
            #1;
            ncyc++;
            chk("state", 32'(state), 32'(c.ph));
            chk("ifu_req_valid", 32'(bus.ifu_req_valid), 32'(c.ph == 0));
            chk("inst_wen", 32'(inst_wen), 32'(c.ph == 1 && c.ifs));
            chk("lsu_req_valid", 32'(bus.lsu_req_valid), 32'(c.ph == 3));
            chk("lsu_req_wen", 32'(bus.lsu_req_wen), 32'(c.ph == 3 && c.dw));
            chk("rf_wen", 32'(rf_wen), 32'(c.ph == 5 && c.drf));
            chk("pc_wen", 32'(pc_wen), 32'(c.ph == 5));
            chk("halt", 32'(halt), 32'(c.ph == 6));
            chk("err", 32'(err), 32'(c.ph == 7));
            chk("err_code", 32'(err_code), 32'(c.ec));
            chk("retire_cnt", 32'(retire_cnt), 32'(c.rc));
        end
    endtask

    initial begin
        bit term;
        drive_zero();
        reset_dut();
        // ALU instructions, zero-wait memory
        push_instr(0, 0, 1, 0, 0, 0, 0, 0, 0, term);
        push_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, term);
        run_plan();
        // Load: ready after 2 cycles, response 3 cycles after acceptance
        push_instr(1, 0, 1, 0, 0, 0, 0, 2, 2, term);
        run_plan();
        // Stores with and without a (bad) rd write
        push_instr(1, 1, 1, 0, 0, 1, 0, 0, 1, term);
        push_instr(1, 1, 0, 0, 0, 0, 0, 1, 0, term);
        run_plan();
        // ebreak beats illegal
        push_instr(0, 0, 1, 1, 1, 0, 0, 0, 0, term);
        push_absorb(20);
        run_plan();

        reset_dut();
        push_instr(0, 0, 1, 0, 1, 0, 1, 0, 0, term);
        push_absorb(5);
        run_plan();

        reset_dut();
        push_instr(0, 0, 0, 0, 0, TO, 0, 0, 0, term);
        push_absorb(5);
        run_plan();

        reset_dut();
        push_instr(0, 0, 1, 0, 0, TO - 1, TO - 1, 0, 0, term);
        push_instr(0, 0, 0, 0, 0, 0, TO, 0, 0, term);
        push_absorb(5);
        run_plan();

        reset_dut();
        push_instr(1, 1, 0, 0, 0, 0, 0, TO - 1, TO - 1, term);
        push_instr(1, 1, 0, 0, 0, 0, 0, TO, 0, term);
        push_absorb(5);
        run_plan();

        reset_dut();
        push_instr(1, 0, 1, 0, 0, 0, 0, 0, TO, term);
        push_absorb(5);
        run_plan();

        // Reset asserted mid-cycle while waiting for load data
        reset_dut();
        push_instr(1, 0, 1, 0, 0, 0, 0, 0, 3, term);
        for (int i = 0; i < 3; i++) void'(plan.pop_back());
        run_plan();
        #2 rst = 1'b1;
        #1;
        chk("abort_mw_lsu_valid", 32'(bus.lsu_req_valid), 32'd0);
        chk("abort_mw_rf_wen", 32'(rf_wen), 32'd0);
        chk("abort_mw_pc_wen", 32'(pc_wen), 32'd0);
        chk("abort_mw_state", 32'(state), 32'd0);
        reset_dut();
        push_instr(0, 0, 1, 0, 0, 0, 0, 0, 0, term);
        push_instr(0, 0, 1, 0, 0, 0, 0, 0, 0, term);
        run_plan();
        // Reset asserted mid-cycle during writeback
        #2 rst = 1'b1;
        #1;
        chk("abort_wb_rf_wen", 32'(rf_wen), 32'd0);
        chk("abort_wb_pc_wen", 32'(pc_wen), 32'd0);
        chk("abort_wb_retire", 32'(retire_cnt), 32'd0);

        // Enough retirements to wrap the counter
        reset_dut();
        for (int i = 0; i < 19; i++)
            push_instr(rb(), rb(), rb(), 0, 0, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                       $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), term);
        run_plan();

        for (int ep = 0; ep < 30; ep++) begin
            reset_dut();
            term = 1'b0;
            for (int k = 0; k < 8 && !term; k++) push_rand(term);
            if (term) push_absorb(4);
            run_plan();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/npc_seq_ctrl.md
Name: npc_seq_ctrl

Overview:
Multi-cycle sequencer for the NPC core: it steps each RV32I instruction through fetch, execute, memory and writeback. It drives valid/ready handshakes to the instruction-fetch and load/store memory ports and gates IR/PC/RF write enables from decoder outputs. It detects ebreak (halt) and illegal opcodes, runs a per-handshake watchdog, and keeps a retired-instruction counter.

Parameters:
TIMEOUT, 255, max cycles spent in any one memory wait state before ERR; 0 disables the watchdog
CNT_W, 32, width of retire_cnt

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  fetch port accepts request
ifu_resp_valid  in  1  fetched instruction present this cycle
inst_wen  out  1  latch fetched instruction into IR (1-cycle pulse)
dec_dram_en  in  1  decoded: instruction accesses data memory
dec_dram_wen  in  1  decoded: access is a store
dec_rf_wen  in  1  decoded: instruction writes rd
dec_ebreak  in  1  decoded: ebreak
dec_illegal  in  1  decoded: opcode/funct unrecognised
lsu_req_valid  out  1  data-memory request valid
lsu_req_ready  in  1  data port accepts request
lsu_req_wen  out  1  request is a write
lsu_resp_valid  in  1  load data or store ack present
rf_wen  out  1  register-file write enable
pc_wen  out  1  PC update enable (next PC computed externally)
halt  out  1  sticky, ebreak reached
err  out  1  sticky, fault
err_code  out  2  0 none, 1 illegal, 2 fetch timeout, 3 mem timeout
retire_cnt  out  CNT_W  instructions retired
state  out  3  current state encoding, for debug

Behaviour:
- States: IF_REQ=0, IF_WAIT=1, EX=2, MEM_REQ=3, MEM_WAIT=4, WB=5, HALT=6, ERR=7. On rst: state=IF_REQ, retire_cnt=0, err_code=0, wait_cnt=0.
- Outputs are Moore decodes of state, except as noted; all are 0 while rst=1.
- IF_REQ: ifu_req_valid=1. On ifu_req_ready -> IF_WAIT.
- IF_WAIT: on ifu_resp_valid, assert inst_wen for that cycle and go to EX.
- EX: the dec_* inputs are valid from IR. Priority: dec_ebreak -> HALT; dec_illegal -> ERR (code 1); dec_dram_en -> MEM_REQ; otherwise -> WB.
- MEM_REQ: lsu_req_valid=1, lsu_req_wen=dec_dram_wen. Valid holds until lsu_req_ready; then -> MEM_WAIT.
- MEM_WAIT: on lsu_resp_valid -> WB. Stores also wait for an ack.
- WB: single cycle. rf_wen=dec_rf_wen, pc_wen=1, retire_cnt+=1 (wraps modulo 2^CNT_W), then -> IF_REQ.
- HALT and ERR are absorbing until rst. While in them, all request and enable outputs are 0 and retire_cnt is frozen.
- resp_valid inputs are ignored outside their WAIT state. A resp in the same cycle as the ready that accepts the request is ignored.
- Watchdog: wait_cnt clears on every state change. In IF_REQ, IF_WAIT, MEM_REQ and MEM_WAIT it increments each cycle without the exiting handshake.
  - If wait_cnt==TIMEOUT-1 and there is no handshake this cycle -> ERR. err_code=2 from IF_*, 3 from MEM_*.
  - A handshake on that same cycle wins, so a state may last at most TIMEOUT cycles.
- Latency with zero-wait memory: ALU/branch/jump instruction 4 cycles; load/store 6 cycles.
- Async reset mid-operation aborts any outstanding request. No pulse of rf_wen or pc_wen is issued for the aborted instruction.

Test Plan:
- Reset, ready=1 in IF_REQ, resp next cycle, dec_rf_wen=1, no mem -> inst_wen in cycle 2, rf_wen and pc_wen pulse in cycle 4, retire_cnt=1, back to IF_REQ in cycle 5.
- Load, lsu_req_ready delayed 2 cycles, resp 3 cycles after acceptance -> lsu_req_valid high 3 cycles with lsu_req_wen=0, rf_wen=1 in WB, retire_cnt+1.
- Store, dec_dram_wen=1, dec_rf_wen=1 (bad decode) -> lsu_req_wen=1; in WB rf_wen follows dec_rf_wen=1 and pc_wen=1. Also run with dec_rf_wen=0 -> rf_wen=0.
- dec_ebreak=1 and dec_illegal=1 together in EX -> HALT (ebreak priority): halt=1, err=0, retire_cnt unchanged, no further ifu_req_valid over 20 cycles.
- TIMEOUT=4, ifu_req_ready held 0 -> ERR after exactly 4 IF_REQ cycles, err_code=2. Rerun with ready=1 on the 4th cycle -> IF_WAIT, err=0.
- Assert rst during MEM_WAIT -> lsu_req_valid, rf_wen and pc_wen drop at once; after release state=IF_REQ, retire_cnt=0, ifu_req_valid=1.
